// File: rtl/mux_arb_n.sv
// ---------------------------------------------------------------------------
// mux_arb_n
//
// Registered N-input multiplexer with a valid/ready handshake on every
// channel and on the output. It sits between several datapath sources of the
// multicycle MIPS (PC, ALUOut, MDR, ...) and one shared sink such as the
// memory address/data port.
//
// Two selection modes:
//   mode = 0 : fixed select. Channel 'sel' is granted whenever it is valid.
//              A 'sel' value outside 0..N_IN-1 grants nothing.
//   mode = 1 : round-robin. Scanning starts at the channel after the one
//              granted last, so every valid source gets a turn under
//              contention.
//
// The chosen word is captured in a single output register one clock after
// the input handshake. A simultaneous output transfer and input transfer
// reload the register without a bubble.
//
// Parameters
//   BIT_WIDTH  data width of each channel
//   N_IN       number of input channels (>= 2, any value)
//   SEL_W      index width, derived from N_IN
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   mode       0 = fixed select by sel, 1 = round-robin over in_valid
//   sel        channel index used in fixed mode
//   in_data    packed channel data, channel i at [i*BIT_WIDTH +: BIT_WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel accept, one-hot or zero
//   out_data   registered selected word
//   out_sel    index of the channel that produced out_data
//   out_valid  out_data/out_sel hold a word for the sink
//   out_ready  sink accepts out_data this cycle
// ---------------------------------------------------------------------------
module mux_arb_n #(
    parameter  int BIT_WIDTH = 32,
    parameter  int N_IN      = 4,
    localparam int SEL_W     = $clog2(N_IN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [N_IN*BIT_WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]           in_valid,
    output logic [N_IN-1:0]           in_ready,
    output logic [BIT_WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Output register and round-robin pointer
    logic [BIT_WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0]     r_out_sel;
    logic                 r_out_valid;
    logic [SEL_W-1:0]     r_rr_ptr;

    // Combinational grant and handshake signals
    logic                 w_load_en;
    logic                 w_grant_any;
    logic [SEL_W-1:0]     w_grant_idx;
    logic [BIT_WIDTH-1:0] w_grant_data;
    logic                 w_take;
    logic [SEL_W-1:0]     w_rr_next;

    // The output register can accept a new word when it is empty or when
    // its current word leaves this same cycle.
    assign w_load_en = !r_out_valid || out_ready;

    // Grant selection. In round-robin mode the channel at offset k from
    // the pointer is (rr_ptr + k) mod N_IN; since both terms are below
    // N_IN the sum is below 2*N_IN, so matching i or i + N_IN covers the
    // wrap without a modulo operator. Earlier offsets win because a grant
    // blocks later matches.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        if (!mode) begin
            for (int i = 0; i < N_IN; i++) begin
                if ((sel == SEL_W'(i)) && in_valid[i]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < N_IN; k++) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (!w_grant_any && in_valid[i] &&
                        ((int'(r_rr_ptr) + k == i) ||
                         (int'(r_rr_ptr) + k == i + N_IN))) begin
                        w_grant_any = 1'b1;
                        w_grant_idx = SEL_W'(i);
                    end
                end
            end
        end
    end

    // Data of the granted channel
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_grant_data = in_data[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    // A grant only exists for a valid channel, so grant plus load enable
    // is a complete input handshake.
    assign w_take = w_grant_any && w_load_en;

    // Ready goes to the granted channel only, and is held low during reset
    // so no source sees a handshake that the register will not keep.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_take && !rst && (w_grant_idx == SEL_W'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Next pointer position: the channel after the one just granted,
    // wrapping explicitly because N_IN need not be a power of two.
    assign w_rr_next = (w_grant_idx == SEL_W'(N_IN - 1)) ? '0
                                                         : w_grant_idx + SEL_W'(1);

    // Output register and round-robin pointer. A new word has priority
    // over clearing valid, which gives the no-bubble reload when the old
    // word leaves in the same cycle. When the word leaves without a
    // replacement only valid drops; data and index keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_take) begin
                r_out_data  <= w_grant_data;
                r_out_sel   <= w_grant_idx;
                r_out_valid <= 1'b1;
                if (mode) begin
                    r_rr_ptr <= w_rr_next;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_arb_n.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_n
//
// Bench for mux_arb_n. A 4-channel instance runs a table of per-cycle
// vectors whose expected in_ready values are written out by hand; every
// expected transfer pushes the expected word into a scoreboard queue, which
// is popped and compared when the sink accepts a word. Hand-written
// sequences cover the fixed-select example, reset in mid-transfer and a
// 3-channel instance with an out-of-range select.
// ---------------------------------------------------------------------------
module tb_mux_arb_n;

    localparam int BW = 32;

    logic clk = 1'b0;
    logic rst;

    // 4-channel instance
    logic          mode;
    logic [1:0]    sel;
    logic [4*BW-1:0] in_data;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [BW-1:0] out_data;
    logic [1:0]    out_sel;
    logic          out_valid;
    logic          out_ready;

    // 3-channel instance
    logic          n3Mode;
    logic [1:0]    n3Sel;
    logic [3*BW-1:0] n3InData;
    logic [2:0]    n3InValid;
    logic [2:0]    n3InReady;
    logic [BW-1:0] n3OutData;
    logic [1:0]    n3OutSel;
    logic          n3OutValid;
    logic          n3OutReady;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       outReady;
        logic [3:0] expReady;
    } vec_t;

    typedef struct {
        logic [BW-1:0] data;
        logic [1:0]    sel;
    } word_t;

    vec_t  tbl[23];
    word_t sb[$];

    mux_arb_n #(.BIT_WIDTH(BW), .N_IN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_arb_n #(.BIT_WIDTH(BW), .N_IN(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (n3Mode),
        .sel       (n3Sel),
        .in_data   (n3InData),
        .in_valid  (n3InValid),
        .in_ready  (n3InReady),
        .out_data  (n3OutData),
        .out_sel   (n3OutSel),
        .out_valid (n3OutValid),
        .out_ready (n3OutReady)
    );

    always #5 clk = ~clk;

    // Channel data for vector v: distinct per vector and per channel, so a
    // word captured from the wrong cycle or channel is visible.
    function automatic logic [BW-1:0] chData(input int v, input int i);
        return {8'(v), 8'(i), 16'h5A5A};
    endfunction

    function automatic int oneHotIdx(input logic [3:0] oh);
        int idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t t, input int v);
        mode      = t.mode;
        sel       = t.sel;
        in_valid  = t.valid;
        out_ready = t.outReady;
        for (int i = 0; i < 4; i++) in_data[i*BW +: BW] = chData(v, i);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic m, input logic [1:0] s,
                                input logic [3:0] v, input logic r,
                                input logic [3:0] e);
        vec_t t;
        t.mode = m; t.sel = s; t.valid = v; t.outReady = r; t.expReady = e;
        return t;
    endfunction

    initial begin
        logic [BW-1:0] lastData;
        logic [1:0]    lastSel;
        word_t         w;

        lastData = '0;
        lastSel  = '0;

        // Fixed mode, then 8 cycles of round-robin fairness, a pause,
        // backpressure with changing inputs, skip/wrap, and a check that
        // fixed mode leaves the pointer alone.
        tbl[0]  = mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100);
        tbl[1]  = mk(1'b0, 2'd0, 4'b1110, 1'b1, 4'b0000);
        tbl[2]  = mk(1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000);
        tbl[3]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);
        tbl[4]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010);
        tbl[5]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100);
        tbl[6]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000);
        tbl[7]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);
        tbl[8]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010);
        tbl[9]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100);
        tbl[10] = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000);
        tbl[11] = mk(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);
        tbl[12] = mk(1'b1, 2'd0, 4'b1100, 1'b1, 4'b0100);
        tbl[13] = mk(1'b1, 2'd0, 4'b0010, 1'b0, 4'b0000);
        tbl[14] = mk(1'b1, 2'd0, 4'b0010, 1'b0, 4'b0000);
        tbl[15] = mk(1'b1, 2'd0, 4'b0010, 1'b0, 4'b0000);
        tbl[16] = mk(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010);
        tbl[17] = mk(1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000);
        tbl[18] = mk(1'b1, 2'd0, 4'b1011, 1'b1, 4'b0001);
        tbl[19] = mk(1'b0, 2'd1, 4'b0011, 1'b1, 4'b0010);
        tbl[20] = mk(1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010);
        tbl[21] = mk(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000);
        tbl[22] = mk(1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000);

        // Reset with inputs already offering data
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        in_data   = '1;
        out_ready = 1'b1;
        n3Mode     = 1'b0;
        n3Sel      = 2'd0;
        n3InValid  = 3'b000;
        n3InData   = '0;
        n3OutReady = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_out_data", out_data, 32'h0);
        checkOutput("rst_out_sel", 32'(out_sel), 32'h0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        in_valid = 4'b0000;
        nextCycle();

        // Table-driven run with scoreboard
        for (int v = 0; v < 23; v++) begin
            applyStimulus(tbl[v], v);
            #1;
            checkOutput($sformatf("v%0d_out_valid", v), 32'(out_valid),
                        32'(sb.size() != 0));
            checkOutput($sformatf("v%0d_in_ready", v), 32'(in_ready),
                        32'(tbl[v].expReady));
            if (sb.size() != 0 && tbl[v].outReady) begin
                w = sb.pop_front();
                checkOutput($sformatf("v%0d_out_data", v), out_data, w.data);
                checkOutput($sformatf("v%0d_out_sel", v), 32'(out_sel), 32'(w.sel));
                lastData = w.data;
                lastSel  = w.sel;
            end
            if (tbl[v].expReady != 4'b0000) begin
                w.sel  = 2'(oneHotIdx(tbl[v].expReady));
                w.data = chData(v, oneHotIdx(tbl[v].expReady));
                sb.push_back(w);
            end
            nextCycle();
        end
        checkOutput("sb_drained", 32'(sb.size()), 32'h0);
        checkOutput("hold_out_data", out_data, lastData);
        checkOutput("hold_out_sel", 32'(out_sel), 32'(lastSel));

        // Fixed select with a known word, then reset while it is held
        mode      = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'b1111;
        in_data   = '0;
        in_data[2*BW +: BW] = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        #1;
        checkOutput("fix_in_ready", 32'(in_ready), 32'h4);
        nextCycle();
        checkOutput("fix_out_data", out_data, 32'hDEAD_BEEF);
        checkOutput("fix_out_sel", 32'(out_sel), 32'h2);
        checkOutput("fix_out_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("midrst_out_data", out_data, 32'h0);
        checkOutput("midrst_out_sel", 32'(out_sel), 32'h0);
        out_ready = 1'b1;
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'h0);
        nextCycle();
        checkOutput("midrst_in_ready_edge", 32'(in_ready), 32'h0);
        checkOutput("midrst_out_valid_edge", 32'(out_valid), 32'h0);
        rst = 1'b0;
        // Pointer was left at 2 by the table; after reset it must start at 0
        mode = 1'b1;
        #1;
        checkOutput("postrst_in_ready", 32'(in_ready), 32'h1);
        nextCycle();
        checkOutput("postrst_out_sel", 32'(out_sel), 32'h0);
        checkOutput("postrst_out_valid", 32'(out_valid), 32'h1);
        in_valid = 4'b0000;
        nextCycle();

        // 3-channel instance: out-of-range select grants nothing
        n3Mode    = 1'b0;
        n3Sel     = 2'd3;
        n3InValid = 3'b111;
        for (int i = 0; i < 3; i++) n3InData[i*BW +: BW] = 32'h3000_0000 + 32'(i);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("n3_sel3_in_ready_%0d", c), 32'(n3InReady), 32'h0);
            checkOutput($sformatf("n3_sel3_out_valid_%0d", c), 32'(n3OutValid), 32'h0);
            nextCycle();
        end
        n3Sel = 2'd2;
        #1;
        checkOutput("n3_sel2_in_ready", 32'(n3InReady), 32'h4);
        nextCycle();
        checkOutput("n3_sel2_out_valid", 32'(n3OutValid), 32'h1);
        checkOutput("n3_sel2_out_sel", 32'(n3OutSel), 32'h2);
        checkOutput("n3_sel2_out_data", n3OutData, 32'h3000_0002);
        // Round-robin on the last channel must wrap the pointer to 0
        n3Mode    = 1'b1;
        n3InValid = 3'b100;
        #1;
        checkOutput("n3_rr_last_in_ready", 32'(n3InReady), 32'h4);
        nextCycle();
        n3InValid = 3'b011;
        #1;
        checkOutput("n3_rr_wrap_in_ready", 32'(n3InReady), 32'h1);
        nextCycle();
        checkOutput("n3_rr_wrap_out_sel", 32'(n3OutSel), 32'h0);
        n3InValid = 3'b000;
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
